// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with full/empty/count and error flags.
// Define STACK_ERR_STICKY_EN for sticky error flags with err_clr.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             push,
  input  logic             pop,
`ifdef STACK_ERR_STICKY_EN
  input  logic             err_clr,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [AW-1:0]    sp_lo;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wa;
  logic             do_push;
  logic             do_pop;
  logic             do_rep;
  logic             ovf_ev;
  logic             unf_ev;
  logic             we;

  assign sp_lo = sp[AW-1:0];
  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == CW'(DEPTH));

  // push+pop on an empty stack behaves as a plain push
  assign do_push = push & (~pop | empty) & ~full;
  assign do_rep  = push & pop & ~empty;
  assign do_pop  = pop & ~push & ~empty;
  assign ovf_ev  = push & ~pop & full;
  assign unf_ev  = pop & ~push & empty;
  assign we      = rst_n & (do_push | do_rep);

  always_comb begin
    rd_idx = '0;
    if (!empty)
      rd_idx = sp_lo - AW'(1);
  end

  assign wa    = do_rep ? rd_idx : sp_lo;
  assign d_out = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push)
        sp <= sp + CW'(1);
      else if (do_pop)
        sp <= sp - CW'(1);
`ifdef STACK_ERR_STICKY_EN
      overflow  <= ovf_ev | (overflow & ~err_clr);
      underflow <= unf_ev | (underflow & ~err_clr);
`else
      overflow  <= ovf_ev;
      underflow <= unf_ev;
`endif
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: DEPTH=4 and DEPTH=5 instances.
// Driver queues expected state; monitor checks after each edge.
module tb_lifo_stack;

`ifdef STACK_ERR_STICKY_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_in = '0;
  logic       err_clr = 1'b0;
  logic       push4 = 1'b0, pop4 = 1'b0;
  logic       push5 = 1'b0, pop5 = 1'b0;
  logic [7:0] d_out4, d_out5;
  logic [2:0] count4, count5;
  logic       empty4, full4, ovf4, unf4;
  logic       empty5, full5, ovf5, unf5;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         sel;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
    string      name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  lifo_stack #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in),
    .push(push4), .pop(pop4),
`ifdef STACK_ERR_STICKY_EN
    .err_clr(err_clr),
`endif
    .d_out(d_out4), .count(count4),
    .empty(empty4), .full(full4),
    .overflow(ovf4), .underflow(unf4)
  );

  lifo_stack #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in),
    .push(push5), .pop(pop5),
`ifdef STACK_ERR_STICKY_EN
    .err_clr(err_clr),
`endif
    .d_out(d_out5), .count(count5),
    .empty(empty5), .full(full5),
    .overflow(ovf5), .underflow(unf5)
  );

  task automatic drv(
    input bit sel, input bit rn, input bit pu,
    input bit po, input logic [7:0] d, input bit clr,
    input logic [2:0] cnt, input logic [7:0] dout,
    input bit ovf, input bit unf, input string name
  );
    exp_t e;
    @(negedge clk);
    rst_n   = rn;
    d_in    = d;
    err_clr = clr;
    push4   = !sel && pu;
    pop4    = !sel && po;
    push5   = sel && pu;
    pop5    = sel && po;
    e.sel  = sel;
    e.dout = dout;
    e.cnt  = cnt;
    e.emp  = (cnt == 0);
    e.ful  = (cnt == (sel ? 3'd5 : 3'd4));
    e.ovf  = ovf;
    e.unf  = unf;
    e.name = name;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] ad;
      logic [2:0] ac;
      logic ae, af, ao, au;
      e = q.pop_front();
      ad = e.sel ? d_out5 : d_out4;
      ac = e.sel ? count5 : count4;
      ae = e.sel ? empty5 : empty4;
      af = e.sel ? full5 : full4;
      ao = e.sel ? ovf5 : ovf4;
      au = e.sel ? unf5 : unf4;
      total++;
      if (ad !== e.dout || ac !== e.cnt || ae !== e.emp ||
          af !== e.ful || ao !== e.ovf || au !== e.unf) begin
        bad++;
        $display("FAIL %s: got d=%h c=%0d e=%b f=%b o=%b u=%b want d=%h c=%0d e=%b f=%b o=%b u=%b",
          e.name, ad, ac, ae, af, ao, au,
          e.dout, e.cnt, e.emp, e.ful, e.ovf, e.unf);
      end
    end
  end

  initial begin
    // reset then idle
    drv(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "rst1");
    drv(0, 0, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, "rst2");
    drv(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "idle5");
    drv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "idle4");
    // fill depth 4 and overflow
    drv(0, 1, 1, 0, 8'h11, 0, 1, 8'h11, 0, 0, "p11");
    drv(0, 1, 1, 0, 8'h22, 0, 2, 8'h22, 0, 0, "p22");
    drv(0, 1, 1, 0, 8'h33, 0, 3, 8'h33, 0, 0, "p33");
    drv(0, 1, 1, 0, 8'h44, 0, 4, 8'h44, 0, 0, "p44");
    drv(0, 1, 1, 0, 8'h55, 0, 4, 8'h44, 1, 0, "ovf");
    drv(0, 1, 0, 0, 8'h00, 0, 4, 8'h44, S, 0, "ovf_after");
    // drain and underflow
    drv(0, 1, 0, 1, 8'h00, 0, 3, 8'h33, S, 0, "pop33");
    drv(0, 1, 0, 1, 8'h00, 0, 2, 8'h22, S, 0, "pop22");
    drv(0, 1, 0, 1, 8'h00, 0, 1, 8'h11, S, 0, "pop11");
    drv(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, S, 0, "pop_empty");
    drv(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, S, 1, "unf");
    drv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, S, S, "unf_after");
    drv(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "rst3");
    // replace-top
    drv(0, 1, 1, 0, 8'h11, 0, 1, 8'h11, 0, 0, "r11");
    drv(0, 1, 1, 0, 8'h22, 0, 2, 8'h22, 0, 0, "r22");
    drv(0, 1, 1, 1, 8'hAA, 0, 2, 8'hAA, 0, 0, "rep_AA");
    drv(0, 1, 0, 1, 8'h00, 0, 1, 8'h11, 0, 0, "rep_pop");
    drv(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, "rep_pop2");
    drv(0, 1, 1, 1, 8'h5C, 0, 1, 8'h5C, 0, 0, "pp_empty");
    drv(0, 1, 1, 1, 8'hC3, 0, 1, 8'hC3, 0, 0, "pp_one");
    // depth 5 boundary
    drv(1, 1, 1, 0, 8'h01, 0, 1, 8'h01, 0, 0, "d5p1");
    drv(1, 1, 1, 0, 8'h02, 0, 2, 8'h02, 0, 0, "d5p2");
    drv(1, 1, 1, 0, 8'h03, 0, 3, 8'h03, 0, 0, "d5p3");
    drv(1, 1, 1, 0, 8'h04, 0, 4, 8'h04, 0, 0, "d5p4");
    drv(1, 1, 1, 0, 8'h05, 0, 5, 8'h05, 0, 0, "d5p5");
    drv(1, 1, 1, 0, 8'h66, 0, 5, 8'h05, 1, 0, "d5ovf");
    drv(1, 1, 1, 1, 8'h77, 0, 5, 8'h77, S, 0, "d5rep_full");
    drv(1, 1, 0, 1, 8'h00, 0, 4, 8'h04, S, 0, "d5pop4");
    drv(1, 1, 1, 0, 8'h88, 0, 5, 8'h88, S, 0, "d5p88");
    drv(1, 1, 0, 1, 8'h00, 0, 4, 8'h04, S, 0, "d5pop4b");
    drv(1, 1, 0, 1, 8'h00, 0, 3, 8'h03, S, 0, "d5pop3");
    drv(1, 1, 0, 1, 8'h00, 0, 2, 8'h02, S, 0, "d5pop2");
    drv(1, 1, 0, 1, 8'h00, 0, 1, 8'h01, S, 0, "d5pop1");
    drv(1, 1, 0, 1, 8'h00, 0, 0, 8'h00, S, 0, "d5pop0");
    drv(1, 1, 1, 0, 8'h09, 0, 1, 8'h09, S, 0, "d5p9");
    drv(1, 0, 1, 0, 8'h0A, 0, 0, 8'h00, 0, 0, "d5rst_push");
    drv(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "d5idle");
`ifdef STACK_ERR_STICKY_EN
    drv(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1, "st_unf");
    for (int i = 0; i < 5; i++)
      drv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, "st_hold");
    drv(0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "st_clr");
    drv(0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 1, "st_unf2");
    drv(0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 1, "st_clr_vs_err");
    drv(0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "st_clr2");
    drv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "st_idle");
`endif
    drv(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "final");
    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
